// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : ps2_host_tx
// Brief    : PS/2 host-to-device command transmitter driving open-drain clk/data.
// Revision : 1.0
//==============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int c_inh_w = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int c_to_w  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [c_inh_w-1:0] c_inh_last   = c_inh_w'(INHIBIT_CYCLES - 1);
    localparam logic [c_to_w-1:0]  c_to_last    = c_to_w'(TIMEOUT_CYCLES - 1);
    localparam logic               c_inh_single = (INHIBIT_CYCLES == 1);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_inhibit = 3'd1;
    localparam logic [2:0] c_st_send    = 3'd2;
    localparam logic [2:0] c_st_ack     = 3'd3;
    localparam logic [2:0] c_st_wait    = 3'd4;

    logic [2:0]         r_state;
    logic               r_clk_s1;
    logic               r_clk_s2;
    logic               r_clk_s3;
    logic               r_data_s1;
    logic               r_data_s2;
    logic [7:0]         r_shift;
    logic               r_parity;
    logic [3:0]         r_bit_idx;
    logic [c_inh_w-1:0] r_inh_cnt;
    logic [c_to_w-1:0]  r_to_cnt;
    logic               r_clk_oe;
    logic               r_data_oe;
    logic               r_done;
    logic               r_error;

    logic [2:0]         w_state_nxt;
    logic [7:0]         w_shift_nxt;
    logic               w_parity_nxt;
    logic [3:0]         w_bit_idx_nxt;
    logic [c_inh_w-1:0] w_inh_cnt_nxt;
    logic [c_to_w-1:0]  w_to_cnt_nxt;
    logic               w_clk_oe_nxt;
    logic               w_data_oe_nxt;
    logic               w_done_nxt;
    logic               w_error_nxt;

    logic               w_fall;
    logic               w_timeout;
    logic [c_inh_w-1:0] w_inh_cnt_inc;
    logic [c_to_w-1:0]  w_to_cnt_inc;

    // Edge detect runs one flop behind the 2-flop synchronizer output.
    assign w_fall        = r_clk_s3 & ~r_clk_s2;
    assign w_timeout     = (r_to_cnt == c_to_last);
    assign w_inh_cnt_inc = r_inh_cnt + 1'b1;
    assign w_to_cnt_inc  = r_to_cnt + 1'b1;

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_parity_nxt  = r_parity;
        w_bit_idx_nxt = r_bit_idx;
        w_inh_cnt_nxt = r_inh_cnt;
        w_to_cnt_nxt  = r_to_cnt;
        w_clk_oe_nxt  = 1'b0;
        w_data_oe_nxt = 1'b0;
        w_done_nxt    = 1'b0;
        w_error_nxt   = 1'b0;

        case (r_state)
            c_st_idle: begin
                if (tx_valid) begin
                    w_shift_nxt   = tx_data;
                    w_parity_nxt  = ~^tx_data;
                    w_bit_idx_nxt = 4'd0;
                    w_inh_cnt_nxt = '0;
                    w_to_cnt_nxt  = '0;
                    w_clk_oe_nxt  = 1'b1;
                    w_data_oe_nxt = c_inh_single;
                    w_state_nxt   = c_st_inhibit;
                end
            end

            c_st_inhibit: begin
                if (r_inh_cnt == c_inh_last) begin
                    // Release clock, keep the start bit on the data line.
                    w_data_oe_nxt = 1'b1;
                    w_bit_idx_nxt = 4'd0;
                    w_to_cnt_nxt  = '0;
                    w_state_nxt   = c_st_send;
                end else begin
                    w_inh_cnt_nxt = w_inh_cnt_inc;
                    w_clk_oe_nxt  = 1'b1;
                    w_data_oe_nxt = (w_inh_cnt_inc == c_inh_last);
                end
            end

            c_st_send: begin
                if (w_timeout) begin
                    w_error_nxt = 1'b1;
                    w_state_nxt = c_st_idle;
                end else begin
                    w_to_cnt_nxt  = w_to_cnt_inc;
                    w_data_oe_nxt = r_data_oe;
                    if (w_fall) begin
                        if (r_bit_idx < 4'd8) begin
                            w_data_oe_nxt = ~r_shift[r_bit_idx[2:0]];
                        end else if (r_bit_idx == 4'd8) begin
                            w_data_oe_nxt = ~r_parity;
                        end else begin
                            w_data_oe_nxt = 1'b0;
                            w_state_nxt   = c_st_ack;
                        end
                        w_bit_idx_nxt = r_bit_idx + 4'd1;
                    end
                end
            end

            c_st_ack: begin
                if (w_timeout) begin
                    w_error_nxt = 1'b1;
                    w_state_nxt = c_st_idle;
                end else begin
                    w_to_cnt_nxt = w_to_cnt_inc;
                    if (w_fall) begin
                        if (r_data_s2) begin
                            w_error_nxt = 1'b1;
                            w_state_nxt = c_st_idle;
                        end else begin
                            w_state_nxt = c_st_wait;
                        end
                    end
                end
            end

            c_st_wait: begin
                if (w_timeout) begin
                    w_error_nxt = 1'b1;
                    w_state_nxt = c_st_idle;
                end else if (r_clk_s2 && r_data_s2) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = c_st_idle;
                end else begin
                    w_to_cnt_nxt = w_to_cnt_inc;
                end
            end

            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_clk_s1  <= 1'b1;
            r_clk_s2  <= 1'b1;
            r_clk_s3  <= 1'b1;
            r_data_s1 <= 1'b1;
            r_data_s2 <= 1'b1;
            r_shift   <= 8'd0;
            r_parity  <= 1'b0;
            r_bit_idx <= 4'd0;
            r_inh_cnt <= '0;
            r_to_cnt  <= '0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_clk_s1  <= ps2_clk_in;
            r_clk_s2  <= r_clk_s1;
            r_clk_s3  <= r_clk_s2;
            r_data_s1 <= ps2_data_in;
            r_data_s2 <= r_data_s1;
            r_shift   <= w_shift_nxt;
            r_parity  <= w_parity_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_inh_cnt <= w_inh_cnt_nxt;
            r_to_cnt  <= w_to_cnt_nxt;
            r_clk_oe  <= w_clk_oe_nxt;
            r_data_oe <= w_data_oe_nxt;
            r_done    <= w_done_nxt;
            r_error   <= w_error_nxt;
        end
    end

    assign tx_ready    = (r_state == c_st_idle);
    assign busy        = (r_state != c_st_idle);
    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
    assign tx_done     = r_done;
    assign tx_error    = r_error;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : tb_ps2_host_tx
// Brief    : Directed bench for ps2_host_tx with a PS/2 device model and scoreboard.
// Revision : 1.0
//==============================================================================
module tb_ps2_host_tx;

    logic       clock;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       tx_done;
    logic       tx_error;

    logic dev_clk_low;
    logic dev_data_low;

    int checks;
    int errors;
    int done_pulses;
    int err_pulses;

    typedef struct {
        logic [7:0] data;
        logic [1:0] outcome;   // 2'b10 done, 2'b01 error, 2'b00 none
    } exp_t;

    exp_t exp_q[$];

    // Open-drain wired-AND of host and device pull-downs.
    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(10),
        .TIMEOUT_CYCLES(5000)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .tx_done    (tx_done),
        .tx_error   (tx_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse monitor pops the outcome scoreboard and checks line invariants.
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            if (!busy) begin
                check("idle_clk_oe", ps2_clk_oe, 1'b0);
                check("idle_data_oe", ps2_data_oe, 1'b0);
            end
            if (tx_done || tx_error) begin
                check("done_and_error", tx_done & tx_error, 1'b0);
                done_pulses += int'(tx_done);
                err_pulses  += int'(tx_error);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("outcome", {tx_done, tx_error}, e.outcome);
                end
            end
        end
    end

    task automatic send_req(input logic [7:0] d, input logic [1:0] outcome);
        exp_t e;
        tx_data  = d;
        tx_valid = 1'b1;
        if (tx_ready) begin
            e.data    = d;
            e.outcome = outcome;
            exp_q.push_back(e);
        end
        @(negedge clock);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
    endtask

    // Device side: measure inhibit, then clock out nedges falling edges.
    task automatic dev_frame(input int nedges, input bit ack,
                             output logic [10:0] bits, output int inh_len, output int data_rise);
        inh_len   = 0;
        data_rise = -1;
        bits      = '0;
        while (ps2_clk_oe && inh_len < 1000) begin
            if (ps2_data_oe && data_rise < 0) data_rise = inh_len;
            inh_len++;
            @(negedge clock);
        end
        bits[0] = ps2_data_in;
        if (nedges > 0) repeat (10) @(negedge clock);
        for (int i = 1; i <= nedges && i <= 10; i++) begin
            dev_clk_low = 1'b1;
            repeat (20) @(negedge clock);
            bits[i] = ps2_data_in;
            dev_clk_low = 1'b0;
            repeat (20) @(negedge clock);
        end
        if (nedges >= 10) begin
            if (exp_q.size() == 0) begin
                check("sb_empty", 0, 1);
            end else begin
                check("sb_data", bits[8:1], exp_q[0].data);
                check("sb_parity", bits[9], ~^exp_q[0].data);
            end
        end
        if (nedges >= 11) begin
            dev_data_low = ack;
            repeat (5) @(negedge clock);
            dev_clk_low = 1'b1;
            repeat (20) @(negedge clock);
            dev_clk_low  = 1'b0;
            dev_data_low = 1'b0;
            repeat (20) @(negedge clock);
        end
    endtask

    task automatic wait_outcome(input int base);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (done_pulses + err_pulses != base) seen = 1'b1;
            else begin
                @(negedge clock);
                #1;
            end
        end
        if (!seen) check("outcome_wait_expired", 0, 1);
    endtask

    initial begin
        logic [10:0] bits;
        int inh, rise, d0, e0, n;

        checks       = 0;
        errors       = 0;
        done_pulses  = 0;
        err_pulses   = 0;
        reset        = 1'b1;
        tx_valid     = 1'b0;
        tx_data      = 8'h00;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;

        repeat (3) @(negedge clock);
        check("rst_tx_ready", tx_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_clk_oe", ps2_clk_oe, 1'b0);
        check("rst_data_oe", ps2_data_oe, 1'b0);
        check("rst_tx_done", tx_done, 1'b0);
        check("rst_tx_error", tx_error, 1'b0);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // 0xED with ACK
        d0 = done_pulses; e0 = err_pulses;
        send_req(8'hED, 2'b10);
        dev_frame(11, 1'b1, bits, inh, rise);
        check("ed_inhibit_len", inh, 10);
        check("ed_data_oe_rise", rise, 9);
        check("ed_start", bits[0], 1'b0);
        check("ed_bits", bits[8:1], 8'hED);
        check("ed_parity", bits[9], 1'b1);
        check("ed_stop", bits[10], 1'b1);
        wait_outcome(d0 + e0);
        check("ed_done_cnt", done_pulses - d0, 1);
        check("ed_err_cnt", err_pulses - e0, 0);
        check("ed_ready", tx_ready, 1'b1);
        repeat (10) @(negedge clock);

        // 0xF4 with ACK: parity 0
        d0 = done_pulses; e0 = err_pulses;
        send_req(8'hF4, 2'b10);
        dev_frame(11, 1'b1, bits, inh, rise);
        check("f4_bits", bits[8:1], 8'hF4);
        check("f4_parity", bits[9], 1'b0);
        wait_outcome(d0 + e0);
        check("f4_done_cnt", done_pulses - d0, 1);
        check("f4_err_cnt", err_pulses - e0, 0);
        repeat (10) @(negedge clock);

        // NACK
        d0 = done_pulses; e0 = err_pulses;
        send_req(8'hA5, 2'b01);
        dev_frame(11, 1'b0, bits, inh, rise);
        wait_outcome(d0 + e0);
        check("nack_err_cnt", err_pulses - e0, 1);
        check("nack_done_cnt", done_pulses - d0, 0);
        check("nack_ready", tx_ready, 1'b1);
        repeat (10) @(negedge clock);

        // Device never clocks: timeout
        d0 = done_pulses; e0 = err_pulses;
        send_req(8'h3C, 2'b01);
        dev_frame(0, 1'b0, bits, inh, rise);
        check("to_inhibit_len", inh, 10);
        n = 0;
        while (!tx_error && n < 6000) begin
            @(negedge clock);
            n++;
        end
        check("to_cycles", n, 5000);
        check("to_clk_oe", ps2_clk_oe, 1'b0);
        check("to_data_oe", ps2_data_oe, 1'b0);
        check("to_ready", tx_ready, 1'b1);
        #1;
        check("to_err_cnt", err_pulses - e0, 1);
        check("to_done_cnt", done_pulses - d0, 0);
        repeat (10) @(negedge clock);

        // Second request while busy is dropped
        d0 = done_pulses; e0 = err_pulses;
        send_req(8'hED, 2'b10);
        repeat (2) @(negedge clock);
        send_req(8'h00, 2'b10);
        dev_frame(11, 1'b1, bits, inh, rise);
        check("busy_bits", bits[8:1], 8'hED);
        wait_outcome(d0 + e0);
        repeat (100) @(negedge clock);
        check("busy_done_cnt", done_pulses - d0, 1);
        check("busy_sb_empty", exp_q.size(), 0);
        check("busy_no_second", busy, 1'b0);
        check("busy_clk_oe", ps2_clk_oe, 1'b0);

        // Reset at bit index 4
        d0 = done_pulses; e0 = err_pulses;
        send_req(8'hED, 2'b00);
        dev_frame(4, 1'b0, bits, inh, rise);
        check("mid_busy", busy, 1'b1);
        reset = 1'b1;
        @(negedge clock);
        check("mid_clk_oe", ps2_clk_oe, 1'b0);
        check("mid_data_oe", ps2_data_oe, 1'b0);
        check("mid_ready", tx_ready, 1'b1);
        reset = 1'b0;
        check("mid_sb_pending", exp_q.size(), 1);
        exp_q.delete();
        repeat (200) @(negedge clock);
        check("mid_no_pulse", (done_pulses - d0) + (err_pulses - e0), 0);

        // Normal transfer after the aborted one
        d0 = done_pulses; e0 = err_pulses;
        send_req(8'hED, 2'b10);
        dev_frame(11, 1'b1, bits, inh, rise);
        check("post_bits", bits[8:1], 8'hED);
        check("post_parity", bits[9], 1'b1);
        wait_outcome(d0 + e0);
        check("post_done_cnt", done_pulses - d0, 1);
        check("post_err_cnt", err_pulses - e0, 0);
        repeat (10) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter: INHIBIT_CYCLES, default 10000, clock-low request hold in `clock` cycles (100 us at 100 MHz).
REQ-002 Parameter: TIMEOUT_CYCLES, default 2000000, transfer timeout in `clock` cycles (20 ms at 100 MHz).
REQ-003 Port: clock  input  1  system clock; all logic is on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: tx_data  input  8  command byte to send to the device.
REQ-006 Port: tx_valid  input  1  request strobe; accepted only when tx_ready=1.
REQ-007 Port: tx_ready  output  1  high when a request can be accepted.
REQ-008 Port: ps2_clk_in / ps2_data_in  input  1 each  raw pad values, asynchronous.
REQ-009 Port: ps2_clk_oe / ps2_data_oe  output  1 each  1 pulls the open-drain line low, 0 releases it.
REQ-010 Port: busy  output  1  high in every state except IDLE; the receiver uses it to ignore host-initiated frames.
REQ-011 Port: tx_done  output  1  one-cycle pulse when the device acknowledges the frame.
REQ-012 Port: tx_error  output  1  one-cycle pulse on NACK or timeout.

Function
REQ-013 ps2_clk_in and ps2_data_in SHALL each pass through a 2-flop synchronizer; a falling edge is synchronized clk going 1 then 0 in consecutive cycles.
REQ-014 States: IDLE, INHIBIT, SEND, ACK, WAIT_IDLE.
REQ-015 IDLE: tx_ready=1, both oe=0; on tx_valid=1, latch tx_data, compute odd parity (~^tx_data), clear counters, and go to INHIBIT next cycle.
REQ-016 tx_valid outside IDLE SHALL be ignored; no request is queued.
REQ-017 INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles; ps2_data_oe SHALL rise in the final INHIBIT cycle (start bit 0).
REQ-018 Go to SEND after INHIBIT: ps2_clk_oe=0, ps2_data_oe held at 1, bit index=0, timeout counter starts.
REQ-019 SEND: on each synchronized falling edge, drive the next bit and then increment the index: edges 1-8 drive data[0..7] (LSB first), edge 9 drives parity, edge 10 drives the stop bit (ps2_data_oe=0); ps2_data_oe = ~bit.
REQ-020 After edge 10, go to ACK: sample synchronized data at the next falling edge (edge 11); 0 = ACK and go to WAIT_IDLE; 1 = NACK, pulse tx_error, go to IDLE.
REQ-021 WAIT_IDLE: when both synchronized lines are 1, pulse tx_done and go to IDLE.
REQ-022 Timeout counter runs in SEND, ACK, and WAIT_IDLE. At TIMEOUT_CYCLES, both oe=0, tx_error pulses, and the state goes to IDLE.
REQ-023 Exactly one of tx_done or tx_error SHALL pulse per accepted request; they are never high together.
REQ-024 ps2_clk_oe SHALL never be 1 outside INHIBIT; ps2_data_oe SHALL never be 1 in IDLE, ACK, or WAIT_IDLE.
REQ-025 Outputs SHALL be registered (no combinational path from inputs to oe/done/error).

Reset
REQ-026 While reset=1 at a clock edge, the next state SHALL be IDLE with: tx_ready=1, busy=0, both oe=0, tx_done=0, tx_error=0, all counters and synchronizers cleared to idle-high values.
REQ-027 Reset mid-transfer SHALL release both lines on the following cycle and produce no done/error pulse.

Verification (bench uses INHIBIT_CYCLES=10, TIMEOUT_CYCLES=5000, device model clocks at ~1/40 of clock)
REQ-028 tx_data=0xED with device ACK:
- clk_oe high for 10 cycles.
- Data line bits after start: 1,0,1,1,0,1,1,1, parity 1, stop 1.
- tx_done pulses once; tx_error stays 0.
REQ-029 tx_data=0xF4 with ACK: parity bit 0 observed by the device model; tx_done pulses once.
REQ-030 Device holds data high at edge 11 (NACK): tx_error pulses once, no tx_done, state back to IDLE with tx_ready=1.
REQ-031 Device never clocks after the inhibit: after 5000 cycles in SEND, tx_error pulses, both oe=0, tx_ready=1.
REQ-032 Second tx_valid=1 (0x00) while busy: ignored; the device model receives only the first byte.
REQ-033 Reset asserted at bit index 4:
- Next cycle: both oe=0 and tx_ready=1.
- No pulse on tx_done or tx_error.
- A subsequent 0xED transfer completes normally.
